des_round_ctrl: RTL and testbench

Sequencer for the iterative DES round datapath. It accepts a start request, steps the shared round function and L/R mux through 16 rounds, and owns the C/D key-schedule register that generates each round's 56-bit pre-PC2 key. It raises an output-valid handshake once the final L/R pair is ready for the inverse permutation. It sits between the top-level control inputs and the round/mux/key-PC2 datapath.

---
 rtl/des_pkg.sv | 21 ++
 rtl/des_cd_rotator.sv | 29 ++
 rtl/des_round_ctrl.sv | 114 +++++++++++
 tb/tb_des_round_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES control constants: widths, FSM state codes and the key-schedule shift table.
package des_pkg;

  localparam int CD_W   = 56;
  localparam int HALF_W = 28;
  localparam int ROUNDS = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ROUND = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Bit n set means round n of the key schedule rotates by 2, otherwise by 1.
  localparam logic [ROUNDS-1:0] SHIFT2_TBL = 16'h7EFC;

  function automatic logic shift_is2(input logic [3:0] n);
    return SHIFT2_TBL[n];
  endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// Combinational rotate of one 28-bit key-schedule half by 1 or 2 places.
// Right rotation exists only when DES_CTRL_DECRYPT_EN is defined; otherwise left-only.
module des_cd_rotator
  import des_pkg::*;
(
  input  logic [HALF_W-1:0] i_din,
  input  logic              i_two,
`ifdef DES_CTRL_DECRYPT_EN
  input  logic              i_left,
`endif
  output logic [HALF_W-1:0] o_dout
);

  logic [HALF_W-1:0] w_rotl;

  assign w_rotl = i_two ? {i_din[HALF_W-3:0], i_din[HALF_W-1:HALF_W-2]}
                        : {i_din[HALF_W-2:0], i_din[HALF_W-1]};

`ifdef DES_CTRL_DECRYPT_EN
  logic [HALF_W-1:0] w_rotr;

  assign w_rotr = i_two ? {i_din[1:0], i_din[HALF_W-1:2]}
                        : {i_din[0], i_din[HALF_W-1:1]};
  assign o_dout = i_left ? w_rotl : w_rotr;
`else
  assign o_dout = w_rotl;
`endif

endmodule

// File: rtl/des_round_ctrl.sv
// 16-round DES sequencer owning the C/D key-schedule register; result valid 17 cycles after start.
// DES_CTRL_DECRYPT_EN enables decrypt key order; without it the decrypt input is ignored.
module des_round_ctrl
  import des_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            decrypt,
  input  logic [CD_W-1:0] cd_init,
  input  logic            out_ready,
  output logic            busy,
  output logic            sel_init,
  output logic            round_en,
  output logic [3:0]      round_idx,
  output logic            last_round,
  output logic [CD_W-1:0] cd_key,
  output logic            out_valid
);

  state_t          r_state;
  logic [3:0]      r_idx;
  logic            r_dec;
  logic            r_first;
  logic [CD_W-1:0] r_cd;

  logic            w_dec_in;
  logic            w_accept;
  logic            w_sh2;
  logic            w_two;
  logic [CD_W-1:0] w_src;
  logic [CD_W-1:0] w_rot;

`ifdef DES_CTRL_DECRYPT_EN
  logic            w_left;
  assign w_dec_in = decrypt;
  assign w_left   = w_accept | ~r_dec;
`else
  assign w_dec_in = decrypt & 1'b0;
`endif

  // A new block is taken from IDLE, or straight out of DONE when the result is consumed.
  assign w_accept = start && ((r_state == ST_IDLE) ||
                              ((r_state == ST_DONE) && out_ready));

  assign w_sh2 = r_dec ? shift_is2(4'd15 - r_idx) : shift_is2(r_idx + 4'd1);

  // The rotators double as the K1 load path (rotl by 1 of cd_init) on acceptance.
  assign w_src = w_accept ? cd_init : r_cd;
  assign w_two = w_accept ? 1'b0 : w_sh2;

  des_cd_rotator u_rot_c (
    .i_din  (w_src[CD_W-1:HALF_W]),
    .i_two  (w_two),
`ifdef DES_CTRL_DECRYPT_EN
    .i_left (w_left),
`endif
    .o_dout (w_rot[CD_W-1:HALF_W])
  );

  des_cd_rotator u_rot_d (
    .i_din  (w_src[HALF_W-1:0]),
    .i_two  (w_two),
`ifdef DES_CTRL_DECRYPT_EN
    .i_left (w_left),
`endif
    .o_dout (w_rot[HALF_W-1:0])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_dec   <= 1'b0;
      r_first <= 1'b0;
      r_cd    <= '0;
    end else if (w_accept) begin
      r_state <= ST_ROUND;
      r_idx   <= 4'd0;
      r_dec   <= w_dec_in;
      r_first <= 1'b1;
      r_cd    <= w_dec_in ? cd_init : w_rot;
    end else begin
      case (r_state)
        ST_ROUND: begin
          r_first <= 1'b0;
          if (r_idx == 4'd15) begin
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 4'd1;
            r_cd  <= w_rot;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (r_state == ST_ROUND) || (r_state == ST_DONE);
  assign round_en   = (r_state == ST_ROUND);
  assign sel_init   = (r_state == ST_ROUND) && r_first;
  assign last_round = (r_state == ST_ROUND) && (r_idx == 4'd15);
  assign round_idx  = r_idx;
  assign cd_key     = r_cd;
  assign out_valid  = (r_state == ST_DONE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Random and directed checks of des_round_ctrl against a cumulative-rotation key-schedule model.
module tb_des_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [55:0] cd_init = '0;
  logic        out_ready = 1'b0;
  logic        busy, sel_init, round_en, last_round, out_valid;
  logic [3:0]  round_idx;
  logic [55:0] cd_key;

  int total = 0;
  int bad   = 0;

`ifdef DES_CTRL_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  int shift_amt [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .decrypt    (decrypt),
    .cd_init    (cd_init),
    .out_ready  (out_ready),
    .busy       (busy),
    .sel_init   (sel_init),
    .round_en   (round_en),
    .round_idx  (round_idx),
    .last_round (last_round),
    .cd_key     (cd_key),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    logic [27:0] y;
    y = x;
    for (int k = 0; k < (n % 28); k++) y = {y[26:0], y[27]};
    return y;
  endfunction

  function automatic int cum_shift(input int i);
    int s;
    s = 0;
    for (int k = 0; k <= i; k++) s += shift_amt[k];
    return s;
  endfunction

  // Encrypt round i uses key K(i+1); decrypt round i uses K(16-i).
  function automatic logic [55:0] exp_key(input logic [55:0] cd, input logic dec, input int i);
    int r;
    r = (dec && DEC_EN) ? cum_shift(15 - i) : cum_shift(i);
    return {rotl28(cd[55:28], r), rotl28(cd[27:0], r)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},       64'(busy),       64'd0);
    chk({tag, ".sel_init"},   64'(sel_init),   64'd0);
    chk({tag, ".round_en"},   64'(round_en),   64'd0);
    chk({tag, ".round_idx"},  64'(round_idx),  64'd0);
    chk({tag, ".last_round"}, 64'(last_round), 64'd0);
    chk({tag, ".cd_key"},     64'(cd_key),     64'd0);
    chk({tag, ".out_valid"},  64'(out_valid),  64'd0);
  endtask

  task automatic chk_round(input int i, input logic [55:0] cd, input logic dec);
    chk("round.busy",       64'(busy),       64'd1);
    chk("round.round_en",   64'(round_en),   64'd1);
    chk("round.sel_init",   64'(sel_init),   64'(i == 0));
    chk("round.last_round", 64'(last_round), 64'(i == 15));
    chk("round.round_idx",  64'(round_idx),  64'(i));
    chk("round.out_valid",  64'(out_valid),  64'd0);
    chk("round.cd_key",     64'(cd_key),     64'(exp_key(cd, dec, i)));
  endtask

  // One block; if started=1 the previous block's final edge already accepted it.
  task automatic run_block(input logic [55:0] cd, input logic dec, input int hold,
                           input bit pulse5, input bit started, input bit chain,
                           input logic [55:0] ncd, input logic ndec);
    if (!started) begin
      cd_init = cd;
      decrypt = dec;
      start   = 1'b1;
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      cd_init = 56'({$urandom(), $urandom()});
      decrypt = 1'($urandom());
      chk_round(i, cd, dec);
      start = (pulse5 && i == 5);
      tick();
    end
    start = 1'b0;
    chk("done.out_valid",  64'(out_valid),  64'd1);
    chk("done.round_en",   64'(round_en),   64'd0);
    chk("done.last_round", 64'(last_round), 64'd0);
    chk("done.round_idx",  64'(round_idx),  64'd15);
    chk("done.cd_key",     64'(cd_key),     64'(exp_key(cd, dec, 15)));
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom());
      tick();
      chk("hold.out_valid", 64'(out_valid), 64'd1);
      chk("hold.round_idx", 64'(round_idx), 64'd15);
      chk("hold.cd_key",    64'(cd_key),    64'(exp_key(cd, dec, 15)));
    end
    start     = chain;
    cd_init   = ncd;
    decrypt   = ndec;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    if (!chain) begin
      chk("idle.busy",      64'(busy),      64'd0);
      chk("idle.out_valid", 64'(out_valid), 64'd0);
      chk("idle.round_en",  64'(round_en),  64'd0);
    end
  endtask

  logic [55:0] r_cd [8];
  logic        r_dec [8];
  int          r_hold [8];
  bit          r_chain [8];

  initial begin
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset.busy", 64'(busy), 64'd0);

    // Directed encrypt with a start pulse mid-round and a 4-cycle stall.
    run_block(56'h0000000_0000001, 1'b0, 4, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("idle2.cd_key", 64'(cd_key[27:0]), 64'h0000001);

    // Directed decrypt, back-to-back into a random encrypt, then a random decrypt.
    run_block(56'h0000000_0000001, 1'b1, 0, 1'b0, 1'b0, 1'b1, 56'h0123456_89ABCDE, 1'b0);
    run_block(56'h0123456_89ABCDE, 1'b0, 2, 1'b0, 1'b1, 1'b1, 56'hF0F0F0F_0F0F0F1, 1'b1);
    run_block(56'hF0F0F0F_0F0F0F1, 1'b1, 1, 1'b0, 1'b1, 1'b0, '0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      r_cd[k]    = 56'({$urandom(), $urandom()});
      r_dec[k]   = 1'($urandom());
      r_hold[k]  = int'($urandom_range(0, 3));
      r_chain[k] = (k < 7) ? 1'($urandom()) : 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      run_block(r_cd[k], r_dec[k], r_hold[k], 1'b0, (k > 0) && r_chain[k-1], r_chain[k],
                (k < 7) ? r_cd[k+1] : 56'd0, (k < 7) ? r_dec[k+1] : 1'b0);
    end

    // Reset mid-round at index 9, then one clean block.
    cd_init = 56'hABCDEF0_1234567;
    decrypt = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("pre_rst.round_idx", 64'(round_idx), 64'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    tick();
    tick();
    chk_zero("held_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("after_rst.out_valid", 64'(out_valid), 64'd0);
    run_block(56'h5A5A5A5_A5A5A5A, 1'b1, 1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
